pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Purpose: qualifies four PLL locks and releases per-domain resets in a fixed, staggered order.
// Latency: dom_rst_n[0] rises 2+LOCK_STABLE_CYCLES edges after all locks are first sampled high.
// Backpressure: none; all outputs are registered status and reset levels.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 16,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int PLL_RST_CYCLES     = 8
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic [3:0] pll_locked,
  input  logic       clr_status,
  output logic       pll_areset,
  output logic [3:0] dom_rst_n,
  output logic       all_ready,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt,
  output logic       timeout_flag
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    PLL_RESET = 3'd4
  } state_t;

  // One shared counter serves as timeout timer, stability counter, release-gap
  // counter and PLL reset pulse counter; only one of them is live per state.
  localparam int MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
  localparam int MAX_CD  = (RELEASE_GAP > PLL_RST_CYCLES) ? RELEASE_GAP : PLL_RST_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(RELEASE_GAP - 1);
  localparam logic [CW-1:0] PRST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rel_idx_q, rel_idx_d;
  logic [3:0]    dom_q, dom_d;
  logic          rdy_q, rdy_d;
  logic          areset_q, areset_d;
  logic [7:0]    llc_q, llc_d;
  logic          to_q, to_d;

  logic          lock_ok;
  logic          loss_evt;
  logic          to_set;

  assign lock_ok = &sync2_q;

  // Next-state logic: synchronizer shift, sequencing FSM and status counters.
  always_comb begin
    sync1_d   = pll_locked;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    rel_idx_d = rel_idx_q;
    dom_d     = dom_q;
    rdy_d     = 1'b0;
    areset_d  = 1'b0;
    loss_evt  = 1'b0;
    to_set    = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        dom_d = 4'h0;
        if (lock_ok) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = PLL_RESET;
          cnt_d    = '0;
          areset_d = 1'b1;
          to_set   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STABILIZE: begin
        dom_d = 4'h0;
        if (!lock_ok) begin
          // Not yet released, so this is not counted as a lock-loss event.
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = RELEASE;
          cnt_d     = '0;
          rel_idx_d = 2'd1;
          dom_d     = 4'b0001;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RELEASE: begin
        if (!lock_ok) begin
          loss_evt = 1'b1;
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          dom_d    = 4'h0;
        end else if (cnt_q == GAP_LAST) begin
          // Bits only ever get set here, so released domains stay released.
          cnt_d            = '0;
          dom_d[rel_idx_q] = 1'b1;
          rel_idx_d        = rel_idx_q + 2'd1;
          if (rel_idx_q == 2'd3) begin
            state_d = RUN;
            rdy_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RUN: begin
        if (!lock_ok) begin
          loss_evt = 1'b1;
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          dom_d    = 4'h0;
        end else begin
          rdy_d = 1'b1;
          dom_d = 4'hF;
        end
      end

      PLL_RESET: begin
        // Lock status is meaningless while the PLLs are held in reset.
        dom_d = 4'h0;
        if (cnt_q == PRST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          areset_d = 1'b1;
          cnt_d    = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        dom_d   = 4'h0;
      end
    endcase

    // Status clear takes priority over a same-cycle increment or set.
    if (clr_status) begin
      llc_d = 8'h00;
      to_d  = 1'b0;
    end else begin
      llc_d = (loss_evt && (llc_q != 8'hFF)) ? (llc_q + 8'h01) : llc_q;
      to_d  = to_q | to_set;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      sync1_q   <= 4'h0;
      sync2_q   <= 4'h0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      rel_idx_q <= 2'd0;
      dom_q     <= 4'h0;
      rdy_q     <= 1'b0;
      areset_q  <= 1'b0;
      llc_q     <= 8'h00;
      to_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_idx_q <= rel_idx_d;
      dom_q     <= dom_d;
      rdy_q     <= rdy_d;
      areset_q  <= areset_d;
      llc_q     <= llc_d;
      to_q      <= to_d;
    end
  end

  assign pll_areset    = areset_q;
  assign dom_rst_n     = dom_q;
  assign all_ready     = rdy_q;
  assign state         = state_q;
  assign lock_loss_cnt = llc_q;
  assign timeout_flag  = to_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: directed scoreboard bench for pll_reset_sequencer with small parameters.
// Latency: expectations are tagged with the absolute clock edge after which they hold.
// Backpressure: none; the monitor compares on every falling edge.
module tb_pll_reset_sequencer;

  localparam int LSC = 8;
  localparam int RG  = 4;
  localparam int LT  = 32;
  localparam int PRC = 3;

  logic       clk_100m = 1'b0;
  logic       rst;
  logic [3:0] pll_locked;
  logic       clr_status;
  logic       pll_areset;
  logic [3:0] dom_rst_n;
  logic       all_ready;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;
  logic       timeout_flag;

  always #5 clk_100m = ~clk_100m;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .RELEASE_GAP       (RG),
    .LOCK_TIMEOUT      (LT),
    .PLL_RST_CYCLES    (PRC)
  ) dut (
    .clk_100m     (clk_100m),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .clr_status   (clr_status),
    .pll_areset   (pll_areset),
    .dom_rst_n    (dom_rst_n),
    .all_ready    (all_ready),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_flag (timeout_flag)
  );

  typedef enum int {F_DOM, F_RDY, F_AR, F_ST, F_LLC, F_TO} fld_t;
  typedef struct {
    int         cyc;
    fld_t       fld;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t  sb[$];
  int    ecount    = 0;
  int    base      = 0;
  int    n_tests   = 0;
  int    n_fail    = 0;
  bit    stim_done = 1'b0;
  string tname     = "init";

  // Count rising edges; expectations refer to this edge number.
  always @(posedge clk_100m) ecount <= ecount + 1;

  function automatic logic [7:0] sample(input fld_t f);
    case (f)
      F_DOM:   return {4'h0, dom_rst_n};
      F_RDY:   return {7'h00, all_ready};
      F_AR:    return {7'h00, pll_areset};
      F_ST:    return {5'h00, state};
      F_LLC:   return lock_loss_cnt;
      default: return {7'h00, timeout_flag};
    endcase
  endfunction

  function automatic string fname(input fld_t f);
    case (f)
      F_DOM:   return "dom_rst_n";
      F_RDY:   return "all_ready";
      F_AR:    return "pll_areset";
      F_ST:    return "state";
      F_LLC:   return "lock_loss_cnt";
      default: return "timeout_flag";
    endcase
  endfunction

  task automatic push_exp(input int k, input fld_t f, input logic [7:0] v);
    exp_t e;
    e.cyc = base + 1 + k;
    e.fld = f;
    e.val = v;
    e.tag = $sformatf("%s.%s@%0d", tname, fname(f), k);
    sb.push_back(e);
  endtask

  task automatic start_test(input string n);
    @(negedge clk_100m);
    base  = ecount;
    tname = n;
  endtask

  // Return at the falling edge that follows relative edge k of the current test.
  task automatic wait_to(input int k);
    while (ecount < base + 1 + k) @(negedge clk_100m);
  endtask

  // Monitor: compare every expectation due at this edge; flush leftovers at the end.
  always @(negedge clk_100m) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= ecount || stim_done) begin
        n_tests++;
        if (sb[i].cyc != ecount) begin
          n_fail++;
          $display("FAIL %s: not checked at its edge (due %0d, now %0d)", sb[i].tag, sb[i].cyc, ecount);
        end else if (sample(sb[i].fld) !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", sb[i].tag, sample(sb[i].fld), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 4'h0;
    clr_status = 1'b0;

    // Reset values.
    start_test("reset");
    push_exp(1, F_DOM, 8'h0); push_exp(1, F_RDY, 8'h0); push_exp(1, F_AR, 8'h0);
    push_exp(1, F_ST, 8'h0);  push_exp(1, F_LLC, 8'h0); push_exp(1, F_TO, 8'h0);
    wait_to(1);

    // Clean power-up: locks high from edge 0.
    start_test("seq");
    rst = 1'b0; pll_locked = 4'hF;
    push_exp(9, F_DOM, 8'h0);  push_exp(9, F_ST, 8'd1);
    push_exp(10, F_DOM, 8'h1); push_exp(10, F_ST, 8'd2);
    push_exp(13, F_DOM, 8'h1); push_exp(14, F_DOM, 8'h3);
    push_exp(17, F_DOM, 8'h3); push_exp(18, F_DOM, 8'h7);
    push_exp(21, F_DOM, 8'h7); push_exp(21, F_RDY, 8'h0);
    push_exp(22, F_DOM, 8'hF); push_exp(22, F_RDY, 8'h1);
    push_exp(22, F_ST, 8'd3);  push_exp(22, F_AR, 8'h0);
    wait_to(30);

    // One-cycle drop of lock[2] while running.
    start_test("glitch");
    pll_locked = 4'hB;
    push_exp(1, F_DOM, 8'hF);  push_exp(1, F_RDY, 8'h1);
    push_exp(2, F_DOM, 8'h0);  push_exp(2, F_RDY, 8'h0);
    push_exp(2, F_LLC, 8'd1);  push_exp(2, F_ST, 8'd0);
    push_exp(10, F_ST, 8'd1);  push_exp(11, F_DOM, 8'h1);
    push_exp(22, F_DOM, 8'h7); push_exp(23, F_DOM, 8'hF);
    push_exp(23, F_RDY, 8'h1); push_exp(23, F_LLC, 8'd1);
    wait_to(0);
    pll_locked = 4'hF;
    wait_to(30);

    // Lock drop while the stability counter is at 5.
    start_test("stab_drop");
    rst = 1'b1;
    push_exp(0, F_DOM, 8'h0);  push_exp(0, F_ST, 8'd0);
    push_exp(0, F_LLC, 8'd0);  push_exp(0, F_RDY, 8'h0);
    push_exp(8, F_ST, 8'd1);   push_exp(9, F_ST, 8'd0);
    push_exp(9, F_LLC, 8'd0);  push_exp(9, F_DOM, 8'h0);
    push_exp(17, F_ST, 8'd1);  push_exp(17, F_DOM, 8'h0);
    push_exp(18, F_DOM, 8'h1); push_exp(30, F_RDY, 8'h1);
    push_exp(30, F_LLC, 8'd0);
    wait_to(0);
    rst = 1'b0;
    wait_to(6);
    pll_locked = 4'hE;
    wait_to(7);
    pll_locked = 4'hF;
    wait_to(35);

    // Reset asserted in the middle of RELEASE.
    start_test("rst_mid");
    rst = 1'b1;
    push_exp(16, F_DOM, 8'h3); push_exp(16, F_ST, 8'd2);
    push_exp(17, F_DOM, 8'h0); push_exp(17, F_RDY, 8'h0);
    push_exp(17, F_AR, 8'h0);  push_exp(17, F_ST, 8'd0);
    push_exp(17, F_LLC, 8'd0); push_exp(17, F_TO, 8'h0);
    push_exp(27, F_ST, 8'd1);  push_exp(27, F_DOM, 8'h0);
    push_exp(28, F_DOM, 8'h1); push_exp(40, F_DOM, 8'hF);
    push_exp(40, F_RDY, 8'h1); push_exp(40, F_ST, 8'd3);
    wait_to(0);
    rst = 1'b0;
    wait_to(16);
    rst = 1'b1;
    wait_to(17);
    rst = 1'b0;
    wait_to(45);

    // Lock[3] never comes up: periodic PLL reset pulses and sticky timeout.
    start_test("timeout");
    rst = 1'b1; pll_locked = 4'h7;
    push_exp(31, F_AR, 8'h0);  push_exp(31, F_TO, 8'h0);  push_exp(31, F_ST, 8'd0);
    push_exp(32, F_AR, 8'h1);  push_exp(32, F_TO, 8'h1);  push_exp(32, F_ST, 8'd4);
    push_exp(32, F_DOM, 8'h0); push_exp(34, F_AR, 8'h1);
    push_exp(35, F_AR, 8'h0);  push_exp(35, F_ST, 8'd0);  push_exp(35, F_TO, 8'h1);
    push_exp(66, F_AR, 8'h0);  push_exp(67, F_AR, 8'h1);
    push_exp(69, F_AR, 8'h1);  push_exp(70, F_AR, 8'h0);
    push_exp(71, F_TO, 8'h0);
    push_exp(102, F_AR, 8'h1); push_exp(102, F_TO, 8'h0); push_exp(102, F_ST, 8'd4);
    push_exp(103, F_TO, 8'h0);
    wait_to(0);
    rst = 1'b0;
    wait_to(70);
    clr_status = 1'b1;
    wait_to(71);
    clr_status = 1'b0;
    wait_to(101);
    clr_status = 1'b1;
    wait_to(102);
    clr_status = 1'b0;
    wait_to(105);

    // 301 lock-loss events during RELEASE, one every 11 edges; the last with clear.
    start_test("sat");
    rst = 1'b1; pll_locked = 4'hF;
    push_exp(10, F_ST, 8'd1); push_exp(11, F_ST, 8'd2); push_exp(12, F_LLC, 8'd0);
    wait_to(0);
    rst = 1'b0;
    for (int i = 0; i <= 300; i++) begin
      int a;
      a = 11 + 11 * i;
      wait_to(a - 1);
      if (i == 0)   begin push_exp(a + 2, F_LLC, 8'd1);   push_exp(a + 2, F_ST, 8'd0); end
      if (i == 253) push_exp(a + 2, F_LLC, 8'd254);
      if (i == 254) push_exp(a + 2, F_LLC, 8'd255);
      if (i == 255) push_exp(a + 2, F_LLC, 8'd255);
      if (i == 299) begin push_exp(a + 1, F_ST, 8'd2);  push_exp(a + 2, F_LLC, 8'd255); end
      if (i == 300) begin push_exp(a + 1, F_LLC, 8'd255); push_exp(a + 2, F_LLC, 8'd0); push_exp(a + 2, F_ST, 8'd0); end
      pll_locked = 4'hB;
      wait_to(a);
      pll_locked = 4'hF;
      if (i == 300) begin
        wait_to(a + 1);
        clr_status = 1'b1;
        wait_to(a + 2);
        clr_status = 1'b0;
      end
    end
    wait_to(11 + 11 * 300 + 6);

    stim_done = 1'b1;
    repeat (3) @(negedge clk_100m);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
